// File: rtl/rst_seq_pkg.sv
// Shared state encoding and sizing helpers for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT    = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } rst_seq_state_t;

  // Bits needed for a counter that runs 0 .. n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Lock inputs, software request and reset/status outputs of the reset sequencer.
interface rst_seq_ctrl_if
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
);

  logic [NUM_CH-1:0] pll_locked_i;
  logic              sw_rst_req_i;
  logic [NUM_CH-1:0] rst_o;
  logic [NUM_CH-1:0] rst_n_o;
  logic              all_rdy_o;
  logic              lock_lost_o;
  logic [CNT_W-1:0]  lock_loss_cnt_o;
  rst_seq_state_t    state_o;

  modport master (
    output pll_locked_i, sw_rst_req_i,
    input  rst_o, rst_n_o, all_rdy_o, lock_lost_o, lock_loss_cnt_o, state_o
  );

  modport slave (
    input  pll_locked_i, sw_rst_req_i,
    output rst_o, rst_n_o, all_rdy_o, lock_lost_o, lock_loss_cnt_o, state_o
  );

endinterface

// File: rtl/sync_ff.sv
// Multi-bit flop-chain synchroniser; every stage clears to 0 on reset.
module sync_ff #(
  parameter int W = 1,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [N-1:0][W-1:0] stages;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages <= {stages[N-2:0], d};
    end
  end

  assign q = stages[N-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: hold, wait for stable PLL locks, release channels in order,
// re-assert everything on lock loss or software request.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int MIN_ASSERT_CYC  = 64,
  parameter int LOCK_STABLE_CYC = 256,
  parameter int STEP_DLY_CYC    = 16,
  parameter int CNT_W           = 8
) (
  input logic          clk,
  input logic          rst_n,
  rst_seq_ctrl_if.slave bus
);

  localparam int TMR_W = cnt_width(max3(MIN_ASSERT_CYC, LOCK_STABLE_CYC, STEP_DLY_CYC));
  localparam int IDX_W = cnt_width(NUM_CH);

  rst_seq_state_t    state, state_nx;
  logic [TMR_W-1:0]  timer, timer_nx;
  logic [IDX_W-1:0]  ch_idx, ch_nx;
  logic [NUM_CH-1:0] rst_q, rst_nx, rst_n_q;
  logic              all_rdy_q, all_rdy_nx;
  logic              lost_q, lost_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_nx;
  logic [NUM_CH-1:0] lock_sync;
  logic              all_locked;
  logic              go_assert;
  logic              lock_loss;

  sync_ff #(.W(NUM_CH), .N(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.pll_locked_i),
    .q     (lock_sync)
  );

  assign all_locked = &lock_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ASSERT;
      timer     <= '0;
      ch_idx    <= '0;
      rst_q     <= '1;
      rst_n_q   <= '0;
      all_rdy_q <= 1'b0;
      lost_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state     <= state_nx;
      timer     <= timer_nx;
      ch_idx    <= ch_nx;
      rst_q     <= rst_nx;
      rst_n_q   <= ~rst_nx;
      all_rdy_q <= all_rdy_nx;
      lost_q    <= lost_nx;
      cnt_q     <= cnt_nx;
    end
  end

  // Lock loss outranks a simultaneous software request so the event is counted.
  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    ch_nx      = ch_idx;
    rst_nx     = rst_q;
    all_rdy_nx = all_rdy_q;
    lost_nx    = 1'b0;
    cnt_nx     = cnt_q;
    go_assert  = 1'b0;
    lock_loss  = 1'b0;

    unique case (state)
      ASSERT: begin
        rst_nx     = '1;
        all_rdy_nx = 1'b0;
        if (bus.sw_rst_req_i) begin
          timer_nx = '0;
        end else if (timer == TMR_W'(MIN_ASSERT_CYC - 1)) begin
          state_nx = WAIT_LOCK;
          timer_nx = '0;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (bus.sw_rst_req_i) begin
          go_assert = 1'b1;
        end else if (!all_locked) begin
          timer_nx = '0;
        end else if (timer == TMR_W'(LOCK_STABLE_CYC - 1)) begin
          timer_nx  = '0;
          rst_nx[0] = 1'b0;
          if (NUM_CH == 1) begin
            state_nx   = RUN;
            all_rdy_nx = 1'b1;
          end else begin
            state_nx = RELEASE;
            ch_nx    = IDX_W'(1);
          end
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      RELEASE: begin
        if (!all_locked) begin
          lock_loss = 1'b1;
        end else if (bus.sw_rst_req_i) begin
          go_assert = 1'b1;
        end else if (timer == TMR_W'(STEP_DLY_CYC - 1)) begin
          timer_nx       = '0;
          rst_nx[ch_idx] = 1'b0;
          if (ch_idx == IDX_W'(NUM_CH - 1)) begin
            state_nx   = RUN;
            all_rdy_nx = 1'b1;
          end else begin
            ch_nx = ch_idx + 1'b1;
          end
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      RUN: begin
        if (!all_locked) begin
          lock_loss = 1'b1;
        end else if (bus.sw_rst_req_i) begin
          go_assert = 1'b1;
        end
      end
      default: go_assert = 1'b1;
    endcase

    if (go_assert || lock_loss) begin
      state_nx   = ASSERT;
      timer_nx   = '0;
      ch_nx      = '0;
      rst_nx     = '1;
      all_rdy_nx = 1'b0;
    end

    if (lock_loss) begin
      lost_nx = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_nx = cnt_q + 1'b1;
      end
    end
  end

  assign bus.rst_o           = rst_q;
  assign bus.rst_n_o         = rst_n_q;
  assign bus.all_rdy_o       = all_rdy_q;
  assign bus.lock_lost_o     = lost_q;
  assign bus.lock_loss_cnt_o = cnt_q;
  assign bus.state_o         = state;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: table of timed vectors plus hand-written corner sequences.
module tb_rst_seq_ctrl;
  import rst_seq_pkg::*;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;

  typedef struct {
    logic [2:0]     locks;
    logic           sw;
    int             adv;
    logic [2:0]     rst;
    logic           rdy;
    logic           lost;
    logic [7:0]     cnt;
    rst_seq_state_t st;
  } vec_t;

  logic clk;
  logic rst_n;
  bit   clk_en;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];

  rst_seq_ctrl_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  rst_seq_ctrl #(
    .NUM_CH          (NUM_CH),
    .SYNC_STAGES     (2),
    .MIN_ASSERT_CYC  (5),
    .LOCK_STABLE_CYC (8),
    .STEP_DLY_CYC    (4),
    .CNT_W           (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] locks, input logic sw);
    bus.pll_locked_i = locks;
    bus.sw_rst_req_i = sw;
  endtask

  task automatic checkOutput(input string tag, input int idx, input logic [2:0] e_rst,
                             input logic e_rdy, input logic e_lost, input logic [7:0] e_cnt,
                             input rst_seq_state_t e_st);
    logic [17:0] act;
    logic [17:0] exp;
    act = {bus.rst_o, bus.rst_n_o, bus.all_rdy_o, bus.lock_lost_o, bus.lock_loss_cnt_o, bus.state_o};
    exp = {e_rst, ~e_rst, e_rdy, e_lost, e_cnt, e_st};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s#%0d: got rst=%b rst_n=%b rdy=%b lost=%b cnt=%0d st=%0d, expected rst=%b rst_n=%b rdy=%b lost=%b cnt=%0d st=%0d",
               tag, idx, bus.rst_o, bus.rst_n_o, bus.all_rdy_o, bus.lock_lost_o,
               bus.lock_loss_cnt_o, int'(bus.state_o), e_rst, ~e_rst, e_rdy, e_lost, e_cnt, int'(e_st));
    end
  endtask

  task automatic checkValue(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] locks, input logic sw, input int adv,
                              input logic [2:0] rst, input logic rdy, input logic lost,
                              input logic [7:0] cnt, input rst_seq_state_t st);
    vec_t v;
    v.locks = locks; v.sw = sw; v.adv = adv; v.rst = rst;
    v.rdy = rdy; v.lost = lost; v.cnt = cnt; v.st = st;
    return v;
  endfunction

  initial begin
    int  exp_cnt;
    bit  seen;
    n_checks = 0;
    n_fail   = 0;
    clk_en   = 1'b1;

    // Power-up sequence with locks already high
    vecs.push_back(mk(3'b111, 0, 1, 3'b111, 0, 0, 0, ASSERT));
    vecs.push_back(mk(3'b111, 0, 3, 3'b111, 0, 0, 0, ASSERT));
    vecs.push_back(mk(3'b111, 0, 1, 3'b111, 0, 0, 0, WAIT_LOCK));
    vecs.push_back(mk(3'b111, 0, 7, 3'b111, 0, 0, 0, WAIT_LOCK));
    vecs.push_back(mk(3'b111, 0, 1, 3'b110, 0, 0, 0, RELEASE));
    vecs.push_back(mk(3'b111, 0, 3, 3'b110, 0, 0, 0, RELEASE));
    vecs.push_back(mk(3'b111, 0, 1, 3'b100, 0, 0, 0, RELEASE));
    vecs.push_back(mk(3'b111, 0, 3, 3'b100, 0, 0, 0, RELEASE));
    vecs.push_back(mk(3'b111, 0, 1, 3'b000, 1, 0, 0, RUN));
    vecs.push_back(mk(3'b111, 0, 5, 3'b000, 1, 0, 0, RUN));
    // Lock[2] lost in RUN, then recovery
    vecs.push_back(mk(3'b011, 0, 2, 3'b000, 1, 0, 0, RUN));
    vecs.push_back(mk(3'b011, 0, 1, 3'b111, 0, 1, 1, ASSERT));
    vecs.push_back(mk(3'b011, 0, 1, 3'b111, 0, 0, 1, ASSERT));
    vecs.push_back(mk(3'b011, 0, 4, 3'b111, 0, 0, 1, WAIT_LOCK));
    vecs.push_back(mk(3'b011, 0, 4, 3'b111, 0, 0, 1, WAIT_LOCK));
    vecs.push_back(mk(3'b111, 0, 9, 3'b111, 0, 0, 1, WAIT_LOCK));
    vecs.push_back(mk(3'b111, 0, 1, 3'b110, 0, 0, 1, RELEASE));
    vecs.push_back(mk(3'b111, 0, 4, 3'b100, 0, 0, 1, RELEASE));
    vecs.push_back(mk(3'b111, 0, 4, 3'b000, 1, 0, 1, RUN));
    // Software pulse in RUN, second pulse extends the hold
    vecs.push_back(mk(3'b111, 1, 1, 3'b111, 0, 0, 1, ASSERT));
    vecs.push_back(mk(3'b111, 0, 2, 3'b111, 0, 0, 1, ASSERT));
    vecs.push_back(mk(3'b111, 1, 1, 3'b111, 0, 0, 1, ASSERT));
    vecs.push_back(mk(3'b111, 0, 4, 3'b111, 0, 0, 1, ASSERT));
    vecs.push_back(mk(3'b111, 0, 1, 3'b111, 0, 0, 1, WAIT_LOCK));
    vecs.push_back(mk(3'b111, 0, 7, 3'b111, 0, 0, 1, WAIT_LOCK));
    vecs.push_back(mk(3'b111, 0, 1, 3'b110, 0, 0, 1, RELEASE));
    vecs.push_back(mk(3'b111, 0, 8, 3'b000, 1, 0, 1, RUN));
    // Lock[1] glitch in WAIT_LOCK at stable count 6 restarts the count
    vecs.push_back(mk(3'b111, 1, 1, 3'b111, 0, 0, 1, ASSERT));
    vecs.push_back(mk(3'b111, 0, 5, 3'b111, 0, 0, 1, WAIT_LOCK));
    vecs.push_back(mk(3'b111, 0, 4, 3'b111, 0, 0, 1, WAIT_LOCK));
    vecs.push_back(mk(3'b101, 0, 1, 3'b111, 0, 0, 1, WAIT_LOCK));
    vecs.push_back(mk(3'b111, 0, 3, 3'b111, 0, 0, 1, WAIT_LOCK));
    vecs.push_back(mk(3'b111, 0, 6, 3'b111, 0, 0, 1, WAIT_LOCK));
    vecs.push_back(mk(3'b111, 0, 1, 3'b110, 0, 0, 1, RELEASE));
    vecs.push_back(mk(3'b111, 0, 8, 3'b000, 1, 0, 1, RUN));

    rst_n = 1'b0;
    applyStimulus(3'b111, 1'b0);
    tick(3);
    checkOutput("reset_hold", 0, 3'b111, 0, 0, 8'd0, ASSERT);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].locks, vecs[i].sw);
      tick(vecs[i].adv);
      checkOutput("vec", i, vecs[i].rst, vecs[i].rdy, vecs[i].lost, vecs[i].cnt, vecs[i].st);
    end

    $display("[TB] simultaneous lock loss and software request");
    applyStimulus(3'b110, 1'b0);
    tick(2);
    checkOutput("sim_pre", 0, 3'b000, 1, 0, 8'd1, RUN);
    applyStimulus(3'b110, 1'b1);
    tick(1);
    checkOutput("sim_loss", 0, 3'b111, 0, 1, 8'd2, ASSERT);
    applyStimulus(3'b111, 1'b0);
    exp_cnt = 2;

    $display("[TB] lock-loss counter saturation");
    for (int ev = 0; ev < 300; ev++) begin
      seen = 1'b0;
      for (int c = 0; c < 60 && !seen; c++) begin
        tick(1);
        if (bus.state_o == RELEASE) seen = 1'b1;
      end
      if (!seen) begin
        checkValue("sat_wait_release", 0, 1);
        break;
      end
      applyStimulus(3'b110, 1'b0);
      seen = 1'b0;
      for (int c = 0; c < 6 && !seen; c++) begin
        tick(1);
        if (bus.lock_lost_o === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
        checkValue("sat_wait_pulse", 0, 1);
        break;
      end
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      checkValue("sat_cnt", int'(bus.lock_loss_cnt_o), exp_cnt);
      applyStimulus(3'b111, 1'b0);
    end
    checkValue("sat_final", int'(bus.lock_loss_cnt_o), 255);

    $display("[TB] async reset mid-release with clock stopped");
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      tick(1);
      if (bus.rst_o === 3'b100) seen = 1'b1;
    end
    checkOutput("mid_release", 0, 3'b100, 0, 0, 8'd255, RELEASE);
    clk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst", 0, 3'b111, 0, 0, 8'd0, ASSERT);
    #20;
    checkOutput("async_rst_hold", 0, 3'b111, 0, 0, 8'd0, ASSERT);
    clk_en = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
